// File: rtl/dmem_load_align.sv
// dmem_load_align: load-return path; registers load attributes in EX and returns an
// aligned, sign/zero-extended write-back result two cycles later. Option: DMEM_MISALIGN_TRAP_EN.
module dmem_load_align #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned RD_W   = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush,
  input  logic [6:0]        opcode,
  input  logic [2:0]        funct,
  input  logic [DATA_W-1:0] addr,
  input  logic [RD_W-1:0]   rd,
  input  logic [DATA_W-1:0] dcache_dout,
  output logic              load_pending,
  output logic              wb_valid,
  output logic [DATA_W-1:0] wb_data,
  output logic [RD_W-1:0]   wb_rd,
  output logic              load_misalign
);

  localparam logic [6:0] OPC_LOAD = 7'b0000011;

  typedef enum logic [2:0] {
    LD_B  = 3'b000,
    LD_H  = 3'b001,
    LD_W  = 3'b010,
    LD_BU = 3'b100,
    LD_HU = 3'b101
  } ld_e;

  logic              r_s1_valid;
  ld_e               r_s1_funct;
  logic [1:0]        r_s1_off;
  logic [RD_W-1:0]   r_s1_rd;
  logic              r_s1_mis;
  logic              r_wb_valid;
  logic [DATA_W-1:0] r_wb_data;
  logic [RD_W-1:0]   r_wb_rd;
  logic              r_mis_pulse;

  logic              w_accept;
  logic              w_mis;
  logic              w_s2_take;
  logic [7:0]        w_byte;
  logic [15:0]       w_half;
  logic [DATA_W-1:0] w_ext;
  logic              w_unused_addr;

  assign w_unused_addr = ^addr[DATA_W-1:2];

  always_comb begin
    w_accept = 1'b0;
    if (opcode == OPC_LOAD) begin
      case (funct)
        LD_B, LD_H, LD_W, LD_BU, LD_HU: w_accept = 1'b1;
        default:                        w_accept = 1'b0;
      endcase
    end
  end

`ifdef DMEM_MISALIGN_TRAP_EN
  always_comb begin
    w_mis = 1'b0;
    case (funct)
      LD_H, LD_HU: w_mis = addr[0];
      LD_W:        w_mis = |addr[1:0];
      default:     w_mis = 1'b0;
    endcase
  end
`else
  assign w_mis = 1'b0;
`endif

  always_comb begin
    w_byte = dcache_dout[7:0];
    case (r_s1_off)
      2'd0: w_byte = dcache_dout[7:0];
      2'd1: w_byte = dcache_dout[15:8];
      2'd2: w_byte = dcache_dout[23:16];
      2'd3: w_byte = dcache_dout[31:24];
      default: w_byte = dcache_dout[7:0];
    endcase
    // Halfword lane chosen by off[1] only, mirroring store-side half placement.
    w_half = r_s1_off[1] ? dcache_dout[31:16] : dcache_dout[15:0];
    w_ext  = dcache_dout;
    case (r_s1_funct)
      LD_B:    w_ext = {{(DATA_W-8){w_byte[7]}}, w_byte};
      LD_BU:   w_ext = {{(DATA_W-8){1'b0}}, w_byte};
      LD_H:    w_ext = {{(DATA_W-16){w_half[15]}}, w_half};
      LD_HU:   w_ext = {{(DATA_W-16){1'b0}}, w_half};
      default: w_ext = dcache_dout;
    endcase
  end

  assign w_s2_take = r_s1_valid & ~flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid  <= 1'b0;
      r_s1_funct  <= LD_B;
      r_s1_off    <= '0;
      r_s1_rd     <= '0;
      r_s1_mis    <= 1'b0;
      r_wb_valid  <= 1'b0;
      r_wb_data   <= '0;
      r_wb_rd     <= '0;
      r_mis_pulse <= 1'b0;
    end else if (stall) begin
      // Fields hold under stall; a concurrent flush still kills both valid bits.
      r_mis_pulse <= 1'b0;
      if (flush) begin
        r_s1_valid <= 1'b0;
        r_wb_valid <= 1'b0;
      end
    end else begin
      r_s1_valid  <= w_accept & ~flush;
      r_s1_funct  <= ld_e'(funct);
      r_s1_off    <= addr[1:0];
      r_s1_rd     <= rd;
      r_s1_mis    <= w_mis;
      r_wb_valid  <= w_s2_take & ~r_s1_mis;
      r_mis_pulse <= w_s2_take & r_s1_mis;
      if (w_s2_take)
        r_wb_rd <= r_s1_rd;
      if (w_s2_take & ~r_s1_mis)
        r_wb_data <= w_ext;
    end
  end

  assign load_pending  = r_s1_valid;
  assign wb_valid      = r_wb_valid;
  assign wb_data       = r_wb_data;
  assign wb_rd         = r_wb_rd;
  assign load_misalign = r_mis_pulse;

endmodule

// File: tb/tb_dmem_load_align.sv
// Self-checking bench for dmem_load_align: vector table, directed corner sequences,
// and randomized traffic against an arithmetic reference model.
module tb_dmem_load_align;

  localparam logic [6:0] OPC_LOAD = 7'b0000011;

  logic        clk = 1'b0;
  logic        rst, stall, flush;
  logic [6:0]  opcode;
  logic [2:0]  funct;
  logic [31:0] addr;
  logic [4:0]  rd;
  logic [31:0] dcache_dout;
  logic        load_pending, wb_valid, load_misalign;
  logic [31:0] wb_data;
  logic [4:0]  wb_rd;

  int total = 0;
  int bad   = 0;

  dmem_load_align #(.DATA_W(32), .RD_W(5)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .opcode(opcode), .funct(funct), .addr(addr), .rd(rd),
    .dcache_dout(dcache_dout),
    .load_pending(load_pending), .wb_valid(wb_valid), .wb_data(wb_data),
    .wb_rd(wb_rd), .load_misalign(load_misalign)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    logic [2:0]  f;
    logic [31:0] a;
    logic [4:0]  r;
    logic [31:0] dout;
    logic [31:0] exp;
  } vec_t;

  vec_t vt[9];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
    end
  endtask

  task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [4:0] r);
    opcode = OPC_LOAD;
    funct  = f;
    addr   = a;
    rd     = r;
  endtask

  task automatic idle();
    opcode = 7'h13;
    funct  = 3'b000;
    addr   = '0;
    rd     = '0;
  endtask

  function automatic bit is_load(input logic [2:0] f);
    return (f == 3'b000) || (f == 3'b001) || (f == 3'b010) || (f == 3'b100) || (f == 3'b101);
  endfunction

  function automatic bit misaligned(input logic [2:0] f, input logic [1:0] off);
    bit trap;
    trap = 1'b0;
`ifdef DMEM_MISALIGN_TRAP_EN
    trap = 1'b1;
`endif
    return trap && ((((f == 3'b001) || (f == 3'b101)) && off[0]) || ((f == 3'b010) && (off != 2'b00)));
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] f, input logic [1:0] off,
                                           input logic [31:0] w);
    longint v;
    case (f)
      3'b000, 3'b100: begin
        v = longint'((w >> (8 * int'(off))) % 256);
        if (f == 3'b000 && v >= 128) v = v - 256;
      end
      3'b001, 3'b101: begin
        v = longint'((w >> (off[1] ? 16 : 0)) % 65536);
        if (f == 3'b001 && v >= 32768) v = v - 65536;
      end
      default: v = longint'(w);
    endcase
    return v[31:0];
  endfunction

  logic        m_s1v, m_wbv, m_mis;
  logic [2:0]  m_f;
  logic [1:0]  m_off;
  logic [4:0]  m_rd, m_rd_out;
  logic [31:0] m_data;
  int          wb_count;

  initial begin
    vt[0] = '{3'b000, 32'h103, 5'd5,  32'h8899AABB, 32'hFFFFFF88};
    vt[1] = '{3'b100, 32'h103, 5'd5,  32'h8899AABB, 32'h00000088};
    vt[2] = '{3'b101, 32'h102, 5'd7,  32'h8899AABB, 32'h00008899};
    vt[3] = '{3'b001, 32'h100, 5'd8,  32'h8899AABB, 32'hFFFFAABB};
    vt[4] = '{3'b010, 32'h100, 5'd9,  32'h8899AABB, 32'h8899AABB};
    vt[5] = '{3'b000, 32'h101, 5'd10, 32'h12345678, 32'h00000056};
    vt[6] = '{3'b001, 32'h102, 5'd11, 32'h80007FFF, 32'hFFFF8000};
    vt[7] = '{3'b100, 32'h100, 5'd31, 32'h000000FF, 32'h000000FF};
    vt[8] = '{3'b000, 32'h102, 5'd1,  32'h00800000, 32'hFFFFFF80};

    rst = 1'b1; stall = 1'b0; flush = 1'b0; dcache_dout = 32'hDEADBEEF;
    idle();
    tick();
    tick();
    chk("reset wb_valid", wb_valid, 0);
    chk("reset wb_data", wb_data, 0);
    chk("reset wb_rd", wb_rd, 0);
    chk("reset load_pending", load_pending, 0);
    chk("reset load_misalign", load_misalign, 0);
    rst = 1'b0;

    // Single loads from the vector table.
    for (int i = 0; i < 9; i++) begin
      issue(vt[i].f, vt[i].a, vt[i].r);
      tick();
      chk($sformatf("vec%0d pending", i), load_pending, 1);
      chk($sformatf("vec%0d early wb_valid", i), wb_valid, 0);
      idle();
      dcache_dout = vt[i].dout;
      tick();
      chk($sformatf("vec%0d wb_valid", i), wb_valid, 1);
      chk($sformatf("vec%0d wb_data", i), wb_data, vt[i].exp);
      chk($sformatf("vec%0d wb_rd", i), wb_rd, vt[i].r);
      dcache_dout = 32'h0;
      tick();
      chk($sformatf("vec%0d wb_valid drop", i), wb_valid, 0);
      chk($sformatf("vec%0d data hold", i), wb_data, vt[i].exp);
    end

    // LB held by a 3-cycle stall.
    wb_count = 0;
    issue(3'b000, 32'h200, 5'd3);
    tick();
    idle();
    stall = 1'b1;
    dcache_dout = 32'h0000007F;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (wb_valid) wb_count++;
      chk("stall wb_valid", wb_valid, 0);
      chk("stall pending", load_pending, 1);
      chk("stall data frozen", wb_data, 32'hFFFFFF80);
    end
    stall = 1'b0;
    tick();
    if (wb_valid) wb_count++;
    chk("stall release wb_data", wb_data, 32'h0000007F);
    chk("stall release wb_rd", wb_rd, 3);
    for (int i = 0; i < 2; i++) begin
      tick();
      if (wb_valid) wb_count++;
    end
    chk("stall writeback count", wb_count, 1);

    // Flush kills S1 load and blocks the EX load.
    issue(3'b010, 32'h300, 5'd4);
    tick();
    chk("flush pre pending", load_pending, 1);
    issue(3'b010, 32'h304, 5'd6);
    flush = 1'b1;
    dcache_dout = 32'h11111111;
    tick();
    chk("flush wb_valid", wb_valid, 0);
    chk("flush pending", load_pending, 0);
    flush = 1'b0;
    idle();
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("post flush wb_valid", wb_valid, 0);
      chk("post flush data", wb_data, 32'h0000007F);
    end

    // Back-to-back LW / LB / LHU.
    issue(3'b010, 32'h400, 5'd12);
    tick();
    issue(3'b000, 32'h401, 5'd13);
    dcache_dout = 32'hCAFEBABE;
    tick();
    chk("b2b lw valid", wb_valid, 1);
    chk("b2b lw data", wb_data, 32'hCAFEBABE);
    chk("b2b lw rd", wb_rd, 12);
    issue(3'b101, 32'h402, 5'd14);
    dcache_dout = 32'h0000F100;
    tick();
    chk("b2b lb valid", wb_valid, 1);
    chk("b2b lb data", wb_data, 32'hFFFFFFF1);
    chk("b2b lb rd", wb_rd, 13);
    idle();
    dcache_dout = 32'hABCD1234;
    tick();
    chk("b2b lhu valid", wb_valid, 1);
    chk("b2b lhu data", wb_data, 32'h0000ABCD);
    chk("b2b lhu rd", wb_rd, 14);
    tick();
    chk("b2b end valid", wb_valid, 0);

    // Misaligned LW.
    issue(3'b010, 32'h101, 5'd15);
    tick();
    idle();
    dcache_dout = 32'h11223344;
    tick();
    chk("mis wb_rd", wb_rd, 15);
`ifdef DMEM_MISALIGN_TRAP_EN
    chk("mis pulse", load_misalign, 1);
    chk("mis wb_valid", wb_valid, 0);
    chk("mis data hold", wb_data, 32'h0000ABCD);
`else
    chk("mis pulse", load_misalign, 0);
    chk("mis wb_valid", wb_valid, 1);
    chk("mis wb_data", wb_data, 32'h11223344);
`endif
    tick();
    chk("mis pulse end", load_misalign, 0);
    chk("mis wb_valid end", wb_valid, 0);

    // Reset asserted mid-stall drops the in-flight load.
    issue(3'b000, 32'h500, 5'd20);
    tick();
    idle();
    stall = 1'b1;
    tick();
    rst = 1'b1;
    tick();
    chk("rst stall wb_valid", wb_valid, 0);
    chk("rst stall wb_data", wb_data, 0);
    chk("rst stall wb_rd", wb_rd, 0);
    chk("rst stall pending", load_pending, 0);
    chk("rst stall misalign", load_misalign, 0);
    rst = 1'b0;
    stall = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst stall no wb", wb_valid, 0);
    end

    // Randomized traffic against the reference model.
    m_s1v = 1'b0; m_wbv = 1'b0; m_mis = 1'b0; m_data = '0; m_rd_out = '0;
    m_f = '0; m_off = '0; m_rd = '0;
    for (int c = 0; c < 400; c++) begin
      opcode      = ($urandom_range(0, 3) != 0) ? OPC_LOAD : 7'h33;
      funct       = 3'($urandom_range(0, 7));
      addr        = $urandom;
      rd          = 5'($urandom_range(0, 31));
      dcache_dout = $urandom;
      stall       = ($urandom_range(0, 4) == 0);
      flush       = ($urandom_range(0, 9) == 0);
      if (!stall) begin
        if (m_s1v && !flush) begin
          m_rd_out = m_rd;
          m_mis    = misaligned(m_f, m_off);
          m_wbv    = !m_mis;
          if (!m_mis) m_data = ref_load(m_f, m_off, dcache_dout);
        end else begin
          m_wbv = 1'b0;
          m_mis = 1'b0;
        end
        m_s1v = (opcode == OPC_LOAD) && is_load(funct) && !flush;
        m_f   = funct;
        m_off = addr[1:0];
        m_rd  = rd;
      end else begin
        m_mis = 1'b0;
        if (flush) begin
          m_s1v = 1'b0;
          m_wbv = 1'b0;
        end
      end
      tick();
      chk("rnd wb_valid", wb_valid, m_wbv);
      chk("rnd pending", load_pending, m_s1v);
      chk("rnd misalign", load_misalign, m_mis);
      chk("rnd wb_data", wb_data, m_data);
      if (m_wbv || m_mis) chk("rnd wb_rd", wb_rd, m_rd_out);
    end

    stall = 1'b0;
    flush = 1'b0;
    idle();
    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dmem_load_align.md
Name: dmem_load_align

Overview:
- Load-return path of the data memory interface: the read-side counterpart of the store byte-enable/data-positioning logic.
- Captures load request attributes in EX (funct, byte offset, rd) alongside the dcache request.
- Extracts and sign/zero-extends the addressed byte/halfword/word from the returned dcache word, then presents a registered write-back result.
- Sits between EX/dcache and the WB mux; supplies a pending-load flag to the hazard unit.

Parameters:
- DATA_W, 32, data path width (`CPU_DATA_BITS)
- RD_W, 5, destination register index width

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- stall  in  1  dcache/pipeline stall; all internal registers hold while high
- flush  in  1  kill in-flight load (branch/jump redirect)
- opcode  in  7  EX-stage opcode
- funct  in  3  EX-stage funct3
- addr  in  DATA_W  EX-stage effective address (ALU result)
- rd  in  RD_W  EX-stage destination register
- dcache_dout  in  DATA_W  dcache read word; valid the cycle after request accept, stable while stall high
- load_pending  out  1  S1 holds a valid load (for load-use hazard)
- wb_valid  out  1  wb_data/wb_rd valid this cycle
- wb_data  out  DATA_W  aligned, extended load result
- wb_rd  out  RD_W  destination of wb_data
- load_misalign  out  1  misaligned-load event (see Optional Feature)

Behaviour:
- Reset (rst=1 at clk edge): s1_valid, wb_valid, load_misalign = 0; wb_data = 0; wb_rd = 0; load_pending = 0. Reset overrides stall and flush. Reset mid-operation drops any in-flight load; no write-back follows.
- Load accepted when opcode==`OPC_LOAD and funct ∈ {LB 000, LH 001, LW 010, LBU 100, LHU 101}. Other funct values are not loads: s1_valid not set.
- Stage S1 (request register): on an edge with stall=0, captures s1_valid = accepted & ~flush, s1_funct, s1_off = addr[1:0], s1_rd. load_pending = s1_valid.
- Stage S2 (output register): on an edge with stall=0, captures wb_valid = s1_valid & ~flush & ~misalign, wb_rd = s1_rd, and wb_data extracted from dcache_dout:
  - LB/LBU: byte s1_off (bits [8*off+7 : 8*off]); sign- or zero-extended to 32 bits.
  - LH/LHU: half selected by s1_off[1] (00/01 → [15:0], 10/11 → [31:16]); sign- or zero-extended.
  - LW: full word.
- When wb_valid=0, wb_data holds its previous value; consumers gate on wb_valid.
- Latency: request in EX at cycle N (stall=0) → wb_valid=1 in cycle N+2. Back-to-back loads give a fully pipelined throughput of 1 per cycle.
- stall=1: S1 and S2 hold all fields, outputs unchanged, no new capture. dcache_dout is sampled only on the releasing edge.
- flush=1 (stall=0): the EX request is not captured and the S1 load is killed (S2 wb_valid=0 next). A load already in S2 completes.
- flush and stall both high: flush wins for S1 and S2 valid bits (both cleared); other fields hold.
- load_misalign is a one-cycle pulse coincident with the S2 capture; 0 in all other cycles.

Optional Feature:
- Macro: DMEM_MISALIGN_TRAP_EN
- Defined:
  - Misalignment is checked at S1 capture: LH/LHU with addr[0]=1, or LW with addr[1:0]≠00.
  - A misaligned load produces load_misalign=1 and wb_valid=0 in the cycle it would have written back; wb_rd is still updated.
  - Flush suppresses the pulse.
- Undefined:
  - No check is made; load_misalign is tied to 0.
  - LH/LHU select the half by off[1], matching the store-side half placement.
  - LW ignores off.

Test Plan:
- dcache_dout=0x8899AABB, LB addr=0x103, rd=5 → two cycles later wb_valid=1, wb_rd=5, wb_data=0xFFFFFF88; repeat as LBU → 0x00000088.
- dcache_dout=0x8899AABB, LHU addr=0x102 → 0x00008899; LH addr=0x100 → 0xFFFFAABB; LW addr=0x100 → 0x8899AABB.
- LB issued, then stall=1 held for 3 cycles with dcache_dout stable at 0x0000007F → outputs frozen during the stall; wb_valid=1 with wb_data=0x0000007F on the cycle after the stall releases; exactly one write-back.
- LW issued, flush=1 on the next cycle → wb_valid stays 0, load_pending falls to 0; a second LW issued in the flush cycle is not captured.
- Back-to-back LW/LB/LHU with no stall → wb_valid high three consecutive cycles with correct per-op data and rd.
- With DMEM_MISALIGN_TRAP_EN: LW addr=0x101 → load_misalign=1 for one cycle, wb_valid=0. Without it: same access → wb_valid=1, wb_data = full dcache word. Also check rst asserted mid-stall → all outputs 0 and no later write-back.
